// File: rtl/uram_readout_sched.sv
// URAM event-buffer scheduler: tracks the slot ring shared by the event writer and the readout SM,
// and hands the buffer to the firmware-load path only between events, with a clean exit back.
module uram_readout_sched #(
  parameter int SLOT_BITS   = 2,
  parameter int FW_PRIORITY = 0,
  parameter int EXIT_CE     = 2,
  parameter int TIMEOUT_CE  = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clk_ce_i,
  input  logic                 ev_done_i,
  output logic [SLOT_BITS-1:0] wr_slot_o,
  output logic                 full_o,
  output logic                 data_available_o,
  output logic [SLOT_BITS-1:0] rd_slot_o,
  input  logic                 complete_i,
  output logic [SLOT_BITS:0]   count_o,
  input  logic                 fw_req_i,
  output logic                 fw_loading_o,
  output logic                 busy_o,
  output logic                 overflow_o,
  output logic                 underflow_o,
  output logic                 timeout_o,
  input  logic                 clr_err_i
);

  localparam logic [SLOT_BITS:0] FULL_CNT  = (SLOT_BITS+1)'(1 << SLOT_BITS);
  localparam logic [15:0]        TMO_MAX   = 16'(TIMEOUT_CE);
  localparam logic [15:0]        TMO_LAST  = 16'(TIMEOUT_CE - 1);
  localparam logic [3:0]         EXIT_LAST = 4'(EXIT_CE - 1);
  localparam logic               FW_PRIO   = (FW_PRIORITY != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READOUT,
    S_FW_ACTIVE,
    S_FW_EXIT
  } state_e;

  state_e               state_q, state_d;
  logic [SLOT_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SLOT_BITS:0]   count_q, count_d;
  logic [15:0]          tmo_cnt_q, tmo_cnt_d;
  logic [3:0]           exit_cnt_q, exit_cnt_d;
  logic                 fw_loading_q, overflow_q, underflow_q, timeout_q;
  logic                 empty, ev_ok, cmp_ok, timeout_set;

  assign empty  = (count_q == '0);
  assign full_o = (count_q == FULL_CNT);
  // A full buffer rejects the write even if a read frees a slot on the same edge.
  assign ev_ok  = ev_done_i && !full_o;
  assign cmp_ok = complete_i && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + SLOT_BITS'(ev_ok);
    rd_ptr_d = rd_ptr_q + SLOT_BITS'(cmp_ok);
    count_d  = count_q;
    if (ev_ok && !cmp_ok)      count_d = count_q + 1'b1;
    else if (!ev_ok && cmp_ok) count_d = count_q - 1'b1;
  end

  // Firmware priority masks pending events at IDLE so the readout SM never sees both grants.
  assign data_available_o = !empty &&
      (state_q == S_READOUT || (state_q == S_IDLE && !(fw_req_i && FW_PRIO)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    exit_cnt_d  = exit_cnt_q;
    timeout_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clk_ce_i) begin
          if (fw_req_i && (empty || FW_PRIO)) state_d = S_FW_ACTIVE;
          else if (data_available_o)          state_d = S_READOUT;
        end
      end
      S_READOUT: begin
        if (complete_i) begin
          state_d   = S_IDLE;
          tmo_cnt_d = '0;
        end else if (clk_ce_i && tmo_cnt_q != TMO_MAX) begin
          tmo_cnt_d   = tmo_cnt_q + 1'b1;
          timeout_set = (tmo_cnt_q == TMO_LAST);
        end
      end
      S_FW_ACTIVE: begin
        if (!fw_req_i) state_d = S_FW_EXIT;
      end
      S_FW_EXIT: begin
        if (clk_ce_i) begin
          if (exit_cnt_q == EXIT_LAST) begin
            state_d    = S_IDLE;
            exit_cnt_d = '0;
          end else begin
            exit_cnt_d = exit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tmo_cnt_q    <= '0;
      exit_cnt_q   <= '0;
      fw_loading_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tmo_cnt_q    <= tmo_cnt_d;
      exit_cnt_q   <= exit_cnt_d;
      fw_loading_q <= (state_d == S_FW_ACTIVE);
      overflow_q   <= (ev_done_i && full_o) || (overflow_q && !clr_err_i);
      underflow_q  <= (complete_i && empty) || (underflow_q && !clr_err_i);
      timeout_q    <= timeout_set || (timeout_q && !clr_err_i);
    end
  end

  assign wr_slot_o    = wr_ptr_q;
  assign rd_slot_o    = rd_ptr_q;
  assign count_o      = count_q;
  assign fw_loading_o = fw_loading_q;
  assign busy_o       = (state_q == S_READOUT);
  assign overflow_o   = overflow_q;
  assign underflow_o  = underflow_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_uram_readout_sched.sv
// Bench for uram_readout_sched: two instances (firmware priority off/on) share stimulus and are
// compared every cycle against a transaction-level model, plus directed scenario checks.
module tb_uram_readout_sched;

  localparam int TMO  = 8;
  localparam int EXIT = 2;
  localparam int NSLOT = 4;

  localparam int M_IDLE = 0, M_RD = 1, M_FWA = 2, M_FWX = 3;

  typedef struct {
    int count, wr, rd, st, tmo, ex;
    bit ov, un, to, fwl;
  } m_t;

  logic clk = 1'b0;
  logic rst, ce, ev, cmp, fwreq, clr;
  logic [13:0] o0, o1;   // {wr[1:0], full, da, rd[1:0], count[2:0], fwl, busy, ov, un, to}
  m_t m0, m1;
  bit chk_en = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uram_readout_sched #(.SLOT_BITS(2), .FW_PRIORITY(0), .EXIT_CE(EXIT), .TIMEOUT_CE(TMO)) dut0 (
    .clk_i(clk), .rst_i(rst), .clk_ce_i(ce), .ev_done_i(ev), .wr_slot_o(o0[13:12]),
    .full_o(o0[11]), .data_available_o(o0[10]), .rd_slot_o(o0[9:8]), .complete_i(cmp),
    .count_o(o0[7:5]), .fw_req_i(fwreq), .fw_loading_o(o0[4]), .busy_o(o0[3]),
    .overflow_o(o0[2]), .underflow_o(o0[1]), .timeout_o(o0[0]), .clr_err_i(clr));

  uram_readout_sched #(.SLOT_BITS(2), .FW_PRIORITY(1), .EXIT_CE(EXIT), .TIMEOUT_CE(TMO)) dut1 (
    .clk_i(clk), .rst_i(rst), .clk_ce_i(ce), .ev_done_i(ev), .wr_slot_o(o1[13:12]),
    .full_o(o1[11]), .data_available_o(o1[10]), .rd_slot_o(o1[9:8]), .complete_i(cmp),
    .count_o(o1[7:5]), .fw_req_i(fwreq), .fw_loading_o(o1[4]), .busy_o(o1[3]),
    .overflow_o(o1[2]), .underflow_o(o1[1]), .timeout_o(o1[0]), .clr_err_i(clr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_da(input m_t m, input bit prio);
    return m.count != 0 && (m.st == M_RD || (m.st == M_IDLE && !(fwreq && prio)));
  endfunction

  function automatic logic [13:0] m_out(input m_t m, input bit prio);
    return {2'(m.wr), m.count == NSLOT, m_da(m, prio), 2'(m.rd), 3'(m.count),
            m.fwl, m.st == M_RD, m.ov, m.un, m.to};
  endfunction

  // One clock of buffer behaviour as described by the occupancy, FSM and flag rules.
  function automatic m_t m_step(input m_t m, input bit prio);
    m_t n = m;
    bit full = (m.count == NSLOT);
    bit ev_ok = ev && !full;
    bit cp_ok = cmp && m.count != 0;
    bit to_set = 1'b0;
    if (rst) return '{0, 0, 0, M_IDLE, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    n.count = m.count + int'(ev_ok) - int'(cp_ok);
    n.wr = (m.wr + int'(ev_ok)) % NSLOT;
    n.rd = (m.rd + int'(cp_ok)) % NSLOT;
    case (m.st)
      M_IDLE: if (ce) begin
        if (fwreq && (m.count == 0 || prio)) n.st = M_FWA;
        else if (m_da(m, prio))              n.st = M_RD;
      end
      M_RD: if (cmp) begin
        n.st = M_IDLE; n.tmo = 0;
      end else if (ce && m.tmo < TMO) begin
        n.tmo = m.tmo + 1; to_set = (n.tmo == TMO);
      end
      M_FWA: if (!fwreq) n.st = M_FWX;
      default: if (ce) begin
        n.ex = m.ex + 1;
        if (n.ex == EXIT) begin n.st = M_IDLE; n.ex = 0; end
      end
    endcase
    n.fwl = (n.st == M_FWA);
    n.ov = (ev && full) || (m.ov && !clr);
    n.un = (cmp && m.count == 0) || (m.un && !clr);
    n.to = to_set || (m.to && !clr);
    return n;
  endfunction

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic tick();
    #1;
    if (chk_en) begin
      check("cycle_dut0", 32'(o0), 32'(m_out(m0, 1'b0)));
      check("cycle_dut1", 32'(o1), 32'(m_out(m1, 1'b1)));
    end
    @(posedge clk);
    m0 = m_step(m0, 1'b0);
    m1 = m_step(m1, 1'b1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ev = 1'b0; cmp = 1'b0; clr = 1'b0; fwreq = 1'b0; ce = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; ev = 1'b0; cmp = 1'b0; fwreq = 1'b0; clr = 1'b0;
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_outputs_dut0", 32'(o0), 32'h0);
    check("reset_outputs_dut1", 32'(o1), 32'h0);

    // Three events written, then read back in slot order.
    ev = 1'b1;
    repeat (3) tick();
    ev = 1'b0;
    check("fill3_count", 32'(o0[7:5]), 32'd3);
    ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmp = 1'b0; tick();
      check("readout_busy", 32'(o0[3]), 32'd1);
      check("readout_rd_slot", 32'(o0[9:8]), 32'(i));
      cmp = 1'b1; tick();
      check("readout_count", 32'(o0[7:5]), 32'(2 - i));
    end
    cmp = 1'b0;
    check("drained_da", 32'(o0[10]), 32'd0);
    check("drained_flags", 32'(o0[2:0]), 32'd0);

    // Overfill, then a write and a read on the same edge while full.
    do_reset();
    ev = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 3) check("full_after_4", 32'(o0[11]), 32'd1);
    end
    check("overflow_set", 32'(o0[2]), 32'd1);
    check("overfill_count", 32'(o0[7:5]), 32'd4);
    check("overfill_wr_slot", 32'(o0[13:12]), 32'd0);
    ce = 1'b1; cmp = 1'b1;
    tick();
    ev = 1'b0; cmp = 1'b0;
    check("full_simul_count", 32'(o0[7:5]), 32'd3);
    check("full_simul_rd_slot", 32'(o0[9:8]), 32'd1);
    check("full_simul_overflow", 32'(o0[2]), 32'd1);

    // Firmware request during readout without priority waits for an empty buffer.
    do_reset();
    ev = 1'b1; repeat (2) tick();
    ev = 1'b0; ce = 1'b1; tick();
    fwreq = 1'b1;
    for (int i = 0; i < 40 && !o0[4]; i++) begin
      cmp = o0[3];
      tick();
    end
    cmp = 1'b0;
    check("fw_granted_after_drain", 32'(o0[4]), 32'd1);
    check("fw_granted_count", 32'(o0[7:5]), 32'd0);
    ev = 1'b1; tick();
    ev = 1'b0; tick();
    check("fw_active_da_masked", 32'(o0[10]), 32'd0);
    fwreq = 1'b0; tick();
    check("fw_exit_loading_low", 32'(o0[4]), 32'd0);
    tick();
    check("fw_exit_ce1_not_busy", 32'(o0[3]), 32'd0);
    tick();
    check("fw_exit_ce2_not_busy", 32'(o0[3]), 32'd0);
    tick();
    check("events_resume", 32'(o0[3]), 32'd1);

    // Priority variant: pending firmware masks a pending event at IDLE.
    do_reset();
    ev = 1'b1; tick();
    ev = 1'b0; fwreq = 1'b1;
    #1;
    check("prio_da_masked", 32'(o1[10]), 32'd0);
    check("noprio_da_visible", 32'(o0[10]), 32'd1);
    ce = 1'b1; tick();
    check("prio_fw_entered", 32'(o1[4]), 32'd1);
    check("noprio_readout_entered", 32'(o0[3]), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("reset_drops_fw_loading", 32'(o1[4]), 32'd0);
    fwreq = 1'b0;

    // Readout timeout, clear, and underflow.
    do_reset();
    ev = 1'b1; tick();
    ev = 1'b0; ce = 1'b1; tick();
    for (int i = 1; i <= TMO; i++) begin
      tick();
      check("timeout_progress", 32'(o0[0]), 32'(i == TMO));
    end
    clr = 1'b1; tick(); clr = 1'b0;
    check("timeout_cleared", 32'(o0[0]), 32'd0);
    do_reset();
    ce = 1'b1; cmp = 1'b1; tick(); cmp = 1'b0;
    check("underflow_set", 32'(o0[1]), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      ce  = ($urandom_range(0, 3) != 0);
      ev  = ($urandom_range(0, 3) == 0);
      cmp = ce && ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) fwreq = ~fwreq;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
